// File: rtl/qam_frame_sync_pkg.sv
// rtl/qam_frame_sync_pkg.sv - shared types and QPSK slicer for the frame synchronizer
package qam_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    HEAD     = 2'd1,
    WAIT_DEC = 2'd2,
    DECODING = 2'd3
  } sync_state_t;

  typedef logic [1:0] sym_t;

  // Gray QPSK decision from the sign bits; zero is treated as non-negative
  function automatic sym_t qpsk_slice(input logic i_msb, input logic q_msb);
    return {~i_msb, ~q_msb};
  endfunction

endpackage

// File: rtl/qam_frame_sync_if.sv
// rtl/qam_frame_sync_if.sv - signed I/Q sample stream from the matched filter
interface qam_frame_sync_if #(
  parameter int W = 4
) ();
  logic                in_valid;
  logic signed [W-1:0] i_rx;
  logic signed [W-1:0] q_rx;

  modport master (output in_valid, output i_rx, output q_rx);
  modport slave  (input  in_valid, input  i_rx, input  q_rx);
endinterface

// File: rtl/qam_frame_sync_correlator.sv
// rtl/qam_frame_sync_correlator.sv - symbol window vs preamble compare with registered popcount
module preamble_correlator #(
  parameter int                     PRE_LEN  = 8,
  parameter logic [2*PRE_LEN-1:0]   PREAMBLE = 16'hE4E4,
  localparam int                    CW       = $clog2(PRE_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [2*PRE_LEN-1:0]   win,
  output logic [CW-1:0]          match_cnt
);

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] r_match_cnt;

  // count window positions whose symbol equals the expected preamble symbol
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < PRE_LEN; k++) begin
      if (win[2*k +: 2] == PREAMBLE[2*k +: 2]) begin
        w_cnt = w_cnt + CW'(1);
      end
    end
  end

  // register the count; clear forces zero so a stale window cannot fire right away
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match_cnt <= '0;
    end else if (clear) begin
      r_match_cnt <= '0;
    end else begin
      r_match_cnt <= w_cnt;
    end
  end

  assign match_cnt = r_match_cnt;

endmodule

// File: rtl/qam_frame_sync.sv
// rtl/qam_frame_sync.sv - QPSK preamble frame synchronizer top (optional SYNC_TIMEOUT_EN)
module qam_frame_sync
  import qam_sync_pkg::*;
#(
  parameter int                     W        = 4,
  parameter int                     PRE_LEN  = 8,
  parameter logic [2*PRE_LEN-1:0]   PREAMBLE = 16'hE4E4,
  parameter int                     THRESH   = 7,
  parameter int                     TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  qam_frame_sync_if.slave        rx,
  input  logic                   is_decoding,
  output sym_t                   sym_out,
  output logic                   sym_valid,
  output logic                   head_detected,
  output logic                   locked
);

  localparam int CW = $clog2(PRE_LEN + 1);

  logic [2*PRE_LEN-1:0] r_win;
  logic [CW-1:0]        r_fill;
  sym_t                 r_sym_out;
  logic                 r_sym_valid;
  sync_state_t          r_state;
  sync_state_t          w_next;
  sym_t                 w_sym;
  logic [CW-1:0]        w_match_cnt;
  logic                 w_full;
  logic                 w_clear;
  logic                 w_timeout;
  logic                 w_unused_lsbs;

  // only the sign bits drive the hard decision
  assign w_unused_lsbs = ^{rx.i_rx[W-2:0], rx.q_rx[W-2:0]};
  assign w_sym  = qpsk_slice(rx.i_rx[W-1], rx.q_rx[W-1]);
  assign w_full = (r_fill == CW'(PRE_LEN));

  // shift the symbol window and forward the tail symbol to the decoder
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win       <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
    end else if (rx.in_valid) begin
      r_win       <= {r_win[2*PRE_LEN-3:0], w_sym};
      r_sym_out   <= r_win[2*PRE_LEN-1 -: 2];
      r_sym_valid <= w_full;
    end else begin
      r_sym_valid <= 1'b0;
    end
  end

  // saturating count of symbols in the window since reset or last release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill <= '0;
    end else if (w_clear) begin
      r_fill <= '0;
    end else if (rx.in_valid && !w_full) begin
      r_fill <= r_fill + CW'(1);
    end
  end

  preamble_correlator #(
    .PRE_LEN  (PRE_LEN),
    .PREAMBLE (PREAMBLE)
  ) u_corr (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .win       (r_win),
    .match_cnt (w_match_cnt)
  );

`ifdef SYNC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_to_cnt;

  // cycles spent in WAIT_DEC; restarts from zero on every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT_DEC) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_to_cnt == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic; leaving lock clears fill and correlation
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_full && (w_match_cnt >= CW'(THRESH)) && !is_decoding) begin
          w_next = HEAD;
        end
      end
      HEAD: begin
        w_next = WAIT_DEC;
      end
      WAIT_DEC: begin
        if (is_decoding) begin
          w_next = DECODING;
        end else if (w_timeout) begin
          w_next  = SEARCH;
          w_clear = 1'b1;
        end
      end
      DECODING: begin
        if (!is_decoding) begin
          w_next  = SEARCH;
          w_clear = 1'b1;
        end
      end
      default: begin
        w_next = SEARCH;
      end
    endcase
  end

  assign sym_out       = r_sym_out;
  assign sym_valid     = r_sym_valid;
  assign head_detected = (r_state == HEAD);
  assign locked        = (r_state != SEARCH);

endmodule

// File: tb/tb_qam_frame_sync.sv
// tb/tb_qam_frame_sync.sv - directed self-checking bench for qam_frame_sync
module tb_qam_frame_sync;
  import qam_sync_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic is_decoding;
  sym_t sym_out;
  logic sym_valid;
  logic head_detected;
  logic locked;

  int n_checks = 0;
  int n_fail   = 0;

  qam_frame_sync_if #(.W(4)) rx_if ();

  qam_frame_sync dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx_if),
    .is_decoding   (is_decoding),
    .sym_out       (sym_out),
    .sym_valid     (sym_valid),
    .head_detected (head_detected),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_iq(input logic signed [3:0] i, input logic signed [3:0] q);
    rx_if.in_valid = 1'b1;
    rx_if.i_rx     = i;
    rx_if.q_rx     = q;
    step();
    rx_if.in_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [1:0] s);
    send_iq(s[1] ? 4'sd3 : -4'sd3, s[0] ? 4'sd3 : -4'sd3);
  endtask

  // sends n symbols of w, oldest in the highest-order pair
  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_sym(w[2*i +: 2]);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    rx_if.in_valid = 1'b0;
    rx_if.i_rx     = '0;
    rx_if.q_rx     = '0;
    is_decoding    = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // watches head_detected for n cycles; returns whether it was seen
  task automatic watch_head(input int n, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      if (head_detected) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    rx_if.in_valid = 1'b0;
    rx_if.i_rx     = '0;
    rx_if.q_rx     = '0;
    is_decoding    = 1'b0;
    step();
    n_checks++; if (head_detected !== 1'b0) begin n_fail++; $display("FAIL reset_head got %b want 0", head_detected); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_checks++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sym_valid got %b want 0", sym_valid); end
    n_checks++; if (sym_out !== 2'b00) begin n_fail++; $display("FAIL reset_sym_out got %b want 00", sym_out); end
    n_checks++; if (dut.r_state !== SEARCH) begin n_fail++; $display("FAIL reset_state got %0d want SEARCH", dut.r_state); end
    reset = 1'b1;
  endtask

  task automatic test_slicer();
    do_reset();
    send_iq(4'sd3, -4'sd2);
    for (int i = 0; i < 7; i++) send_iq(4'sd0, 4'sd0);
    n_checks++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL slicer_not_full_valid got %b want 0", sym_valid); end
    send_iq(4'sd0, 4'sd0);
    n_checks++; if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL slicer_first_valid got %b want 1", sym_valid); end
    n_checks++; if (sym_out !== 2'b10) begin n_fail++; $display("FAIL slicer_pos_neg got %b want 10", sym_out); end
    send_iq(4'sd0, 4'sd0);
    n_checks++; if (sym_out !== 2'b11) begin n_fail++; $display("FAIL slicer_zero got %b want 11", sym_out); end
    n_checks++; if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL slicer_second_valid got %b want 1", sym_valid); end
    step();
    n_checks++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL slicer_idle_valid got %b want 0", sym_valid); end
  endtask

  task automatic test_exact();
    do_reset();
    send_word(16'hE4E4, 8);
    n_checks++; if (head_detected !== 1'b0) begin n_fail++; $display("FAIL exact_head_t0 got %b want 0", head_detected); end
    step();
    n_checks++; if (head_detected !== 1'b0) begin n_fail++; $display("FAIL exact_head_t1 got %b want 0", head_detected); end
    step();
    n_checks++; if (head_detected !== 1'b1) begin n_fail++; $display("FAIL exact_head_t2 got %b want 1", head_detected); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL exact_locked_t2 got %b want 1", locked); end
    step();
    n_checks++; if (head_detected !== 1'b0) begin n_fail++; $display("FAIL exact_head_t3 got %b want 0", head_detected); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL exact_locked_t3 got %b want 1", locked); end
  endtask

  task automatic test_errors();
    logic seen;
    do_reset();
    send_word(16'hE4E5, 8);
    step();
    step();
    n_checks++; if (head_detected !== 1'b1) begin n_fail++; $display("FAIL one_error_head got %b want 1", head_detected); end
    do_reset();
    send_word(16'hE4E1, 8);
    watch_head(6, seen);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL two_error_head got %b want 0", seen); end
    do_reset();
    send_word(16'hE4E4, 7);
    watch_head(6, seen);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL short_fill_head got %b want 0", seen); end
  endtask

  task automatic test_decode_cycle();
    logic seen;
    do_reset();
    send_word(16'hE4E4, 8);
    step();
    step();
    step();
    n_checks++; if (dut.r_state !== WAIT_DEC) begin n_fail++; $display("FAIL dec_wait_state got %0d want WAIT_DEC", dut.r_state); end
    is_decoding = 1'b1;
    step();
    n_checks++; if (dut.r_state !== DECODING) begin n_fail++; $display("FAIL dec_busy_state got %0d want DECODING", dut.r_state); end
    repeat (9) step();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL dec_locked_busy got %b want 1", locked); end
    is_decoding = 1'b0;
    step();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL dec_release_locked got %b want 0", locked); end
    n_checks++; if (dut.r_state !== SEARCH) begin n_fail++; $display("FAIL dec_release_state got %0d want SEARCH", dut.r_state); end
    watch_head(4, seen);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dec_stale_window got %b want 0", seen); end
    is_decoding = 1'b1;
    send_word(16'hE4E4, 8);
    watch_head(5, seen);
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL busy_no_detect got %b want 0", seen); end
    is_decoding = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(16'hE4E4, 8);
    step();
    step();
    step();
    is_decoding = 1'b1;
    step();
    step();
    is_decoding = 1'b0;
    step();
    send_word(16'hE4E4, 8);
    n_checks++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_refill_valid got %b want 0", sym_valid); end
    step();
    step();
    n_checks++; if (head_detected !== 1'b1) begin n_fail++; $display("FAIL b2b_second_head got %b want 1", head_detected); end
    send_sym(2'b01);
    n_checks++; if (sym_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_head_sample_valid got %b want 1", sym_valid); end
    n_checks++; if (sym_out !== 2'b11) begin n_fail++; $display("FAIL b2b_head_sample_out got %b want 11", sym_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(16'hE4E4, 8);
    step();
    step();
    step();
    is_decoding = 1'b1;
    step();
    n_checks++; if (dut.r_state !== DECODING) begin n_fail++; $display("FAIL mid_pre_state got %0d want DECODING", dut.r_state); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_locked got %b want 0", locked); end
    n_checks++; if (head_detected !== 1'b0) begin n_fail++; $display("FAIL mid_reset_head got %b want 0", head_detected); end
    n_checks++; if (dut.r_state !== SEARCH) begin n_fail++; $display("FAIL mid_reset_state got %0d want SEARCH", dut.r_state); end
    do_reset();
  endtask

  task automatic test_wait_dec();
    do_reset();
    send_word(16'hE4E4, 8);
    step();
    step();
`ifdef SYNC_TIMEOUT_EN
    repeat (64) step();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_before got %b want 1", locked); end
    step();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_drop got %b want 0", locked); end
`else
    repeat (100) step();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wait_forever_locked got %b want 1", locked); end
    n_checks++; if (dut.r_state !== WAIT_DEC) begin n_fail++; $display("FAIL wait_forever_state got %0d want WAIT_DEC", dut.r_state); end
`endif
  endtask

  initial begin
    test_reset();
    test_slicer();
    test_exact();
    test_errors();
    test_decode_cycle();
    test_back_to_back();
    test_reset_mid();
    test_wait_dec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
